mem_arbiter: RTL and testbench

Shares the single external memory port (program ROM / data RAM behind the memory controller) between the control unit's instruction-fetch path and the datapath's load/store path. It accepts one outstanding request per side and alternates grants under contention. It drives one registered transaction at a time to the memory controller. A per-transaction watchdog aborts accesses the controller never acknowledges.

---
 rtl/mem_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter for the single external memory port
//
// Purpose: shares one memory-controller port between the instruction-fetch
// side and the load/store side. One outstanding request per side, grants
// alternate under contention, one registered transaction at a time, and a
// per-transaction watchdog aborts accesses the controller never acknowledges.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   if_req, if_addr            fetch request, held until if_ack
//   if_ack, if_rdata, if_err   one-cycle fetch completion with byte / abort flag
//   d_req, d_we, d_addr,
//   d_wdata                    data request, held until d_ack
//   d_ack, d_rdata, d_err      one-cycle data completion with byte / abort flag
//   mem_req, mem_we, mem_addr,
//   mem_wdata                  registered transaction to the memory controller
//   mem_ack, mem_rdata         controller completion pulse and read byte
//   busy                       high whenever the arbiter is not idle
module mem_arbiter #(
  parameter int ADDR_W  = 23,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  // Counter is at least 8 bits, wider only if TIMEOUT needs it.
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam bit WDOG_EN = (TIMEOUT > 0);
  // The counter holds the number of GNT cycles already spent without an ack,
  // so the abort fires in the TIMEOUT-th GNT cycle, when it reads TIMEOUT-1.
  localparam logic [CNT_W-1:0] CNT_LAST = WDOG_EN ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_D  = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              last_d_q, last_d_d;   // 1: data side won the last grant
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              mem_req_d, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic              if_ack_d, if_err_d, d_ack_d, d_err_d;
  logic [DATA_W-1:0] if_rdata_d, d_rdata_d;
  logic              busy_d;
  logic              pick_d;
  logic              timed_out;

  always_comb begin
    state_d     = state_q;
    last_d_d    = last_d_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    if_rdata_d  = if_rdata;
    if_err_d    = if_err;
    d_rdata_d   = d_rdata;
    d_err_d     = d_err;
    pick_d      = 1'b0;
    timed_out   = 1'b0;

    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          // Data wins when alone, or under contention when fetch won last.
          pick_d    = d_req && (!if_req || !last_d_q);
          last_d_d  = pick_d;
          mem_req_d = 1'b1;
          cnt_d     = '0;
          if (pick_d) begin
            state_d     = GNT_D;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
          end else begin
            state_d     = GNT_IF;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
          end
        end
      end

      GNT_IF, GNT_D: begin
        // An ack in the timeout cycle still counts as a normal completion.
        timed_out = WDOG_EN && !mem_ack && (cnt_q == CNT_LAST);
        if (mem_ack || timed_out) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          if (state_q == GNT_IF) begin
            if_ack_d   = 1'b1;
            if_err_d   = timed_out;
            if_rdata_d = timed_out ? '1 : mem_rdata;
          end else begin
            d_ack_d   = 1'b1;
            d_err_d   = timed_out;
            // Write completions return a zero byte.
            d_rdata_d = mem_we ? '0 : (timed_out ? '1 : mem_rdata);
          end
        end else if (WDOG_EN) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_d_q  <= 1'b0;
      cnt_q     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ack    <= 1'b0;
      if_rdata  <= '0;
      if_err    <= 1'b0;
      d_ack     <= 1'b0;
      d_rdata   <= '0;
      d_err     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_d_q  <= last_d_d;
      cnt_q     <= cnt_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      if_ack    <= if_ack_d;
      if_rdata  <= if_rdata_d;
      if_err    <= if_err_d;
      d_ack     <= d_ack_d;
      d_rdata   <= d_rdata_d;
      d_err     <= d_err_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard testbench for mem_arbiter
module tb_mem_arbiter;

  localparam int ADDR_W = 23;
  localparam int DATA_W = 8;
  localparam int TO     = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;
  logic              if_err;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
  );

  int checks = 0;
  int passed = 0;

  typedef struct packed {
    logic       err;
    logic [7:0] rdata;
  } resp_t;

  resp_t      q_if[$];
  resp_t      q_d[$];
  int         k_plan[$];          // forced ack cycle for upcoming grants
  logic [7:0] mem_model[int];     // written bytes of the external memory

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  function automatic logic [7:0] rd_model(input logic [22:0] a);
    if (mem_model.exists(int'(a))) return mem_model[int'(a)];
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_req"}, mem_req, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_if_ack"}, if_ack, 0);
    chk({tag, "_d_ack"}, d_ack, 0);
    chk({tag, "_if_rdata"}, if_rdata, 0);
    chk({tag, "_d_rdata"}, d_rdata, 0);
    chk({tag, "_if_err"}, if_err, 0);
    chk({tag, "_d_err"}, d_err, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // Monitor and memory-controller model: predicts each grant from the
  // arbitration rule, decides the controller's ack cycle, queues the
  // expected response and checks acks as they appear.
  bit         in_txn, last_d, side_d, tx_we;
  int         gcyc, k, exp_hi;
  logic [22:0] tx_addr;
  logic [7:0] tx_wdata, tx_rd;
  resp_t      e;

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    in_txn    = 1'b0;
    last_d    = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q_if.delete();
        q_d.delete();
        in_txn  = 1'b0;
        last_d  = 1'b0;
        mem_ack = 1'b0;
      end else begin
        chk("busy", busy, mem_req | if_ack | d_ack);
        chk("ack_exclusive", if_ack & d_ack, 0);
        if (if_ack) begin
          if (q_if.size() == 0) chk("if_ack_expected", 0, 1);
          else begin
            e = q_if.pop_front();
            chk("if_rdata", if_rdata, e.rdata);
            chk("if_err", if_err, e.err);
          end
        end
        if (d_ack) begin
          if (q_d.size() == 0) chk("d_ack_expected", 0, 1);
          else begin
            e = q_d.pop_front();
            chk("d_rdata", d_rdata, e.rdata);
            chk("d_err", d_err, e.err);
          end
        end

        if (mem_req && !in_txn) begin
          in_txn = 1'b1;
          gcyc   = 0;
          if (!if_req && !d_req) begin
            chk("grant_has_req", 0, 1);
            side_d = 1'b0;
          end else begin
            side_d = (if_req && d_req) ? !last_d : d_req;
          end
          last_d   = side_d;
          tx_we    = side_d ? d_we : 1'b0;
          tx_addr  = side_d ? d_addr : if_addr;
          tx_wdata = side_d ? d_wdata : 8'h00;
          chk("grant_we", mem_we, tx_we);
          chk("grant_addr", mem_addr, tx_addr);
          if (tx_we) chk("grant_wdata", mem_wdata, tx_wdata);
          k       = (k_plan.size() > 0) ? k_plan.pop_front() : $urandom_range(1, 6);
          exp_hi  = (k > TO) ? TO : k;
          tx_rd   = rd_model(tx_addr);
          e.err   = (k > TO);
          e.rdata = tx_we ? 8'h00 : (e.err ? 8'hFF : tx_rd);
          if (tx_we && !e.err) mem_model[int'(tx_addr)] = tx_wdata;
          if (side_d) q_d.push_back(e);
          else q_if.push_back(e);
        end

        if (in_txn) begin
          if (mem_req) begin
            gcyc++;
            chk("hold_addr", mem_addr, tx_addr);
            chk("hold_we", mem_we, tx_we);
            mem_ack   = (gcyc == k);
            mem_rdata = (gcyc == k) ? tx_rd : 8'($urandom);
          end else begin
            in_txn = 1'b0;
            chk("mem_req_cycles", gcyc, exp_hi);
            chk("ack_in_resp", side_d ? d_ack : if_ack, 1);
            mem_ack   = ($urandom_range(0, 3) == 0);
            mem_rdata = 8'($urandom);
          end
        end else begin
          // Stray acks outside a transaction must be ignored.
          mem_ack   = ($urandom_range(0, 3) == 0);
          mem_rdata = 8'($urandom);
        end
      end
    end
  end

  task automatic wait_ack(input bit side, input string tag);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(side ? d_ack : if_ack) && t < 200);
    chk(tag, side ? d_ack : if_ack, 1);
    #1;
  endtask

  task automatic run_fetch(input int n, input int gap_max, input logic [22:0] a0, input bit rnd);
    for (int i = 0; i < n; i++) begin
      int gap;
      gap = $urandom_range(0, gap_max);
      if (gap > 0) begin
        if_req = 1'b0;
        repeat (gap) @(negedge clk);
        #1;
      end
      if_addr = rnd ? 23'($urandom_range(0, 31)) : a0;
      if_req  = 1'b1;
      wait_ack(1'b0, "if_ack_timely");
    end
    if_req = 1'b0;
  endtask

  task automatic run_data(input int n, input int gap_max, input bit we0,
                          input logic [22:0] a0, input logic [7:0] wd0, input bit rnd);
    for (int i = 0; i < n; i++) begin
      int gap;
      gap = $urandom_range(0, gap_max);
      if (gap > 0) begin
        d_req = 1'b0;
        repeat (gap) @(negedge clk);
        #1;
      end
      d_we    = rnd ? 1'($urandom_range(0, 1)) : we0;
      d_addr  = rnd ? (23'h400000 + 23'($urandom_range(0, 15))) : a0;
      d_wdata = rnd ? 8'($urandom) : wd0;
      d_req   = 1'b1;
      wait_ack(1'b1, "d_ack_timely");
    end
    d_req = 1'b0;
  endtask

  initial begin
    int t, acks_seen;
    rst_n   = 1'b0;
    if_req  = 1'b0;
    if_addr = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    mem_model[32'h10] = 8'h5A;

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    #1 rst_n = 1'b1;

    // Contention straight out of reset: data first, then fetch.
    k_plan.push_back(1);
    k_plan.push_back(1);
    fork
      run_data(1, 0, 1'b1, 23'h400001, 8'hC3, 1'b0);
      run_fetch(1, 0, 23'h000020, 1'b0);
    join

    // Single fetch, ack in the second grant cycle.
    k_plan.push_back(2);
    run_fetch(1, 0, 23'h000010, 1'b0);

    // Sustained contention, three requests per side reissued at once.
    fork
      run_fetch(3, 0, '0, 1'b1);
      run_data(3, 0, 1'b0, '0, 8'h00, 1'b1);
    join

    // Watchdog abort on a data read, then a normal fetch.
    k_plan.push_back(99);
    run_data(1, 0, 1'b0, 23'h400005, 8'h00, 1'b0);
    k_plan.push_back(1);
    run_fetch(1, 0, 23'h000004, 1'b0);

    // Ack in the exact timeout cycle completes normally.
    k_plan.push_back(TO);
    run_data(1, 0, 1'b0, 23'h400001, 8'h00, 1'b0);
    k_plan.push_back(TO);
    run_fetch(1, 0, 23'h000010, 1'b0);

    // Asynchronous reset in the middle of a fetch grant.
    k_plan.push_back(99);
    if_addr = 23'h000011;
    if_req  = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!mem_req && t < 20);
    chk("reset_test_granted", mem_req, 1);
    #3 rst_n = 1'b0;
    #1 chk_all_zero("async_reset");
    if_req = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    acks_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (if_ack || d_ack) acks_seen++;
    end
    chk("no_ack_after_reset", acks_seen, 0);
    #1;
    k_plan.delete();
    fork
      run_data(1, 0, 1'b0, 23'h400002, 8'h00, 1'b0);
      run_fetch(1, 0, 23'h000003, 1'b0);
    join

    // Randomized traffic on both sides.
    fork
      run_fetch(30, 3, '0, 1'b1);
      run_data(30, 3, 1'b0, '0, 8'h00, 1'b1);
    join

    repeat (4) @(negedge clk);
    chk("if_queue_drained", q_if.size(), 0);
    chk("d_queue_drained", q_d.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish before 500000");
    $fatal(1, "simulation time limit");
  end

endmodule
